// File: rtl/mem_access_unit.sv
// Load/store unit bridging byte/half/word requests onto a word-wide RAM with a
// one-edge registered read; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_write_enable,
  input  logic [31:0] mem_data_out
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t      state, state_next;
  logic        write_q, unsigned_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic        accept, req_err;
  logic [32:0] nbytes;
  logic [31:0] load_ext, merged;

  assign accept = req_valid && (state == S_IDLE);

  // Range check in 33 bits so addresses near 0xFFFFFFFF cannot wrap into range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    nbytes = 33'd4;
    case (req_size)
      SZ_BYTE: nbytes = 33'd1;
      SZ_HALF: nbytes = 33'd2;
      default: nbytes = 33'd4;
    endcase
    req_err = (req_size == 2'b11)
           || (req_size == SZ_HALF && req_addr[0])
           || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
           || (({1'b0, req_addr} + nbytes) > 33'(MEM_BYTES));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) begin
        if (req_err)                             state_next = S_DONE;
        else if (req_write && req_size == SZ_WORD) state_next = S_WRITE;
        else                                     state_next = S_READ;
      end
      S_READ:  state_next = S_WAIT;
      S_WAIT:  state_next = write_q ? S_WRITE : S_DONE;
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Little-endian lane extraction of the RAM word for loads.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = mem_data_out[7:0];
    case (addr_q[1:0])
      2'd0: b = mem_data_out[7:0];
      2'd1: b = mem_data_out[15:8];
      2'd2: b = mem_data_out[23:16];
      2'd3: b = mem_data_out[31:24];
      default: b = mem_data_out[7:0];
    endcase
    h = addr_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_ext = unsigned_q ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_ext = mem_data_out;
    endcase
  end

  // Replace only the addressed lane(s); the rest of the RAM word is preserved.
  always_comb begin
    merged = mem_data_out;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_data_out;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
      if (accept) begin
        write_q    <= req_write;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        if (req_err) begin
          resp_rdata <= 32'h0;
          resp_error <= 1'b1;
        end
      end
      if (state == S_WAIT) begin
        if (write_q) begin
          merge_q <= merged;
        end else begin
          resp_rdata <= load_ext;
          resp_error <= 1'b0;
        end
      end
      if (state == S_WRITE) begin
        resp_rdata <= 32'h0;
        resp_error <= 1'b0;
      end
    end
  end

  // Outputs decode from state, so reset drops the write strobe without waiting for clk.
  assign req_ready        = (state == S_IDLE);
  assign resp_valid       = (state == S_DONE);
  assign mem_address      = {addr_q[31:2], 2'b00};
  assign mem_write_enable = (state == S_WRITE);
  assign mem_data_in      = (state != S_WRITE) ? 32'h0 :
                            (size_q == SZ_WORD) ? wdata_q : merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: word RAM model, directed vector
// table, and a reset-during-write sequence.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write_enable;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  logic [31:0] ram [0:255];

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Word RAM with registered read, read-before-write on the same edge.
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_address[9:2]] <= mem_data_in;
    mem_data_out <= ram[mem_address[9:2]];
    if (mem_write_enable) we_count <= we_count + 1;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
    int          we;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err,
                              input int cycles, input int we);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.cycles = cycles; v.we = we;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns at the negedge of
  // the IDLE cycle after DONE, so consecutive calls are back-to-back.
  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    int we0;
    bit got;
    logic [31:0] rd;
    we0 = we_count;
    check({name, " ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    cyc = 1;
    got = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) got = 1'b1;
    end
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no resp_valid within %0d cycles", name, cyc);
    end
    check({name, " cycles"}, 32'(cyc), 32'(v.cycles));
    check({name, " rdata"}, resp_rdata, v.rdata);
    check({name, " error"}, {31'h0, resp_error}, {31'h0, v.err});
    rd = resp_rdata;
    @(negedge clk);
    check({name, " pulse"}, {31'h0, resp_valid}, 32'h0);
    check({name, " hold"}, resp_rdata, rd);
    check({name, " strobes"}, 32'(we_count - we0), 32'(v.we));
  endtask

  initial begin
    int we0;
    bit saw_valid;
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;

    //         wr    size   uns   addr           wdata          rdata          err  cyc we
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'h8899_AABB, 32'h0,         1'b0, 3, 1));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h0102_0304, 32'h0,         1'b0, 3, 1));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         1'b0, 3, 1));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0,         32'hFFFF_FFAA, 1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'h0,         32'h0000_8899, 1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         32'h8899_AABB, 1'b0, 4, 0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0004, 32'hFFFF_FF11, 32'h0,         1'b0, 5, 1));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         32'h8899_AA11, 1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0007, 32'h0,         32'h0000_0088, 1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0004, 32'h0,         32'hFFFF_AA11, 1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0,         32'hFFFF_8899, 1'b0, 4, 0));
    vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'hABCD_1234, 32'h0,         1'b0, 5, 1));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_AA11, 1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,         32'h0,         1'b1, 2, 0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0,         32'h0,         1'b1, 2, 0));
    vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1, 2, 0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1, 2, 0));
    vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0000_0055, 32'h0,         1'b1, 2, 0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1, 2, 0));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_03FD, 32'h0000_005A, 32'h0,         1'b0, 5, 1));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_5A0D, 1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_03FF, 32'h0,         32'hFFFF_FFCA, 1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_03FE, 32'h0,         32'h0000_CAFE, 1'b0, 4, 0));
    vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0,         1'b1, 2, 0));
    vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         32'h0102_0304, 1'b0, 4, 0));
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0009, 32'h0,         32'h0000_0003, 1'b0, 4, 0));

    #1;
    check("rst req_ready",  {31'h0, req_ready},        32'h1);
    check("rst resp_valid", {31'h0, resp_valid},       32'h0);
    check("rst resp_rdata", resp_rdata,                32'h0);
    check("rst resp_error", {31'h0, resp_error},       32'h0);
    check("rst mem_addr",   mem_address,               32'h0);
    check("rst mem_wdata",  mem_data_in,               32'h0);
    check("rst mem_we",     {31'h0, mem_write_enable}, 32'h0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));
    check("ram word1", ram[1], 32'h1234_AA11);

    // Reset asserted while the word store sits in WRITE.
    we0 = we_count;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0008; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("wr strobe before rst", {31'h0, mem_write_enable}, 32'h1);
    check("wr data before rst", mem_data_in, 32'hDEAD_BEEF);
    #2 reset = 1'b0;
    #1;
    check("mid rst mem_we",     {31'h0, mem_write_enable}, 32'h0);
    check("mid rst req_ready",  {31'h0, req_ready},        32'h1);
    check("mid rst mem_addr",   mem_address,               32'h0);
    check("mid rst resp_rdata", resp_rdata,                32'h0);
    saw_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid) saw_valid = 1'b1;
    end
    check("mid rst no resp", {31'h0, saw_valid}, 32'h0);
    reset = 1'b1;
    check("mid rst strobes", 32'(we_count - we0), 32'h0);
    check("ram word2 kept", ram[2], 32'h0102_0304);
    run_vec(mk(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'h0102_0304, 1'b0, 4, 0), "post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MEM_BYTES, default 1024, data-memory size in bytes (256 words); must be a multiple of 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 req_valid  input  1  access request present.
REQ-005 req_ready  output  1  unit idle, request accepted this cycle if req_valid=1.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00=byte, 01=halfword, 10=word, 11=illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  one-cycle pulse, access complete.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_error  output  1  access rejected (misaligned, illegal size or out of range); valid with resp_valid.
REQ-014 mem_address  output  32  byte address to word RAM (RAM uses bits [31:2]).
REQ-015 mem_data_in  output  32  write word to RAM.
REQ-016 mem_write_enable  output  1  RAM write strobe.
REQ-017 mem_data_out  input  32  RAM read word, registered by RAM one edge after address is presented.

Function
REQ-018 FSM states IDLE, READ, WAIT, WRITE, DONE; req_ready=1 only in IDLE.
REQ-019 Accept on req_valid&&req_ready; latch write, size, unsigned, addr, wdata; unaccepted requests ignored, no queueing.
REQ-020 Error check at accept: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr+bytes > MEM_BYTES; on error go IDLE->DONE, no RAM write, resp_error=1, resp_rdata=0.
REQ-021 Load: IDLE->READ->WAIT->DONE; resp_valid high in the 4th cycle counting the accept cycle as 1.
REQ-022 In READ and WAIT, mem_address=latched addr with [1:0] forced to 00, mem_write_enable=0.
REQ-023 At WAIT->DONE edge, register resp_rdata from mem_data_out: lane select by addr[1:0], little-endian (addr 0 -> bits [7:0]), byte/half extended per req_unsigned.
REQ-024 Word store: IDLE->WRITE->DONE; in WRITE mem_write_enable=1, mem_data_in=wdata.
REQ-025 Sub-word store: IDLE->READ->WAIT->WRITE->DONE; merge register captures mem_data_out at WAIT->WRITE with addressed byte/half replaced from wdata, other bytes preserved; WRITE drives merged word.
REQ-026 mem_write_enable=1 only in WRITE, exactly one cycle per store.
REQ-027 DONE lasts one cycle, resp_valid=1, then ->IDLE; resp_rdata/resp_error held until next DONE.
REQ-028 Back-to-back: request presented in cycle after DONE is accepted (one IDLE cycle minimum between accesses).
REQ-029 Address wrap: no 32-bit wrap check beyond REQ-020; addr near 0xFFFFFFFF is an out-of-range error.

Reset
REQ-030 reset=0 forces immediately, independent of clk: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_address=0, mem_data_in=0, mem_write_enable=0, latches/merge register 0.
REQ-031 Reset mid-access abandons it with no response; reset during WRITE deasserts mem_write_enable before the next edge, so no RAM write occurs.
REQ-032 First accept possible on first rising edge with reset=1.

Verification
REQ-033 RAM word 1=0x8899AABB; load byte signed addr 0x5 -> resp_rdata=0xFFFFFFAA, error 0, resp_valid in 4th cycle.
REQ-034 Same word; load half unsigned addr 0x6 -> 0x00008899; load word addr 0x4 -> 0x8899AABB.
REQ-035 Store byte 0x11 to addr 0x4 over 0x8899AABB -> one write strobe, RAM word 1=0x8899AA11; following word load returns 0x8899AA11.
REQ-036 Load half addr 0x3, word addr 0x2, size 11, word addr 0x400 (MEM_BYTES=1024) -> each resp_error=1, resp_rdata=0, no mem_write_enable pulse, DONE 2nd cycle.
REQ-037 Word store 0xDEADBEEF to addr 0x8 with reset=0 asserted during WRITE -> no resp_valid, mem_write_enable=0 immediately, RAM word 2 unchanged; post-reset load addr 0x8 works.
